// File: rtl/trackball_pkg.sv
// Shared types and helpers for the trackball counter bank: per-line state,
// synchroniser depth and parameter legality limits.
package trackball_pkg;

  localparam int unsigned SYNC_STAGES  = 2;
  localparam int unsigned HIST_MAX_W   = 16;
  localparam int unsigned DIV_MIN      = 2;
  localparam int unsigned FILT_LEN_MIN = 1;

  // One raw input line: synchroniser, tick history, filtered level, level at previous tick
  typedef struct packed {
    logic [SYNC_STAGES-1:0] sync;
    logic [HIST_MAX_W-1:0]  hist;
    logic                   filt;
    logic                   prev;
  } chan_state_t;

  function automatic bit params_legal(input int unsigned div, input int unsigned filt_len,
                                      input int unsigned nchan);
    return (div >= DIV_MIN) && (filt_len >= FILT_LEN_MIN) && (filt_len <= HIST_MAX_W) &&
           (nchan >= 1);
  endfunction

  // Next state of one line; history bits above the filter length stay zero via mask
  function automatic chan_state_t line_step(input chan_state_t s, input logic raw,
                                            input logic tick, input logic [HIST_MAX_W-1:0] mask);
    chan_state_t           n;
    logic [HIST_MAX_W-1:0] h;
    n      = s;
    h      = '0;
    n.sync = {s.sync[SYNC_STAGES-2:0], raw};
    if (tick) begin
      h      = ((s.hist << 1) | HIST_MAX_W'(s.sync[SYNC_STAGES-1])) & mask;
      n.hist = h;
      n.prev = s.filt;
      if (&(h | ~mask)) n.filt = 1'b1;
      else if (h == '0) n.filt = 1'b0;
    end
    return n;
  endfunction

endpackage

// File: rtl/tb_chan_decoder.sv
// One trackball channel: CLK/DIR sync and glitch filter, edge detect, up/down counter, clear.
// TRACKBALL_SAT_EN defined: counter saturates at signed limits instead of wrapping.
module tb_chan_decoder
  import trackball_pkg::*;
#(
  parameter int unsigned CNT_W    = 8,
  parameter int unsigned FILT_LEN = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_tick,
  input  logic             i_resoln,
  input  logic             i_clk_raw,
  input  logic             i_dir_raw,
  input  logic             i_clr,
  output logic [CNT_W-1:0] o_cnt
);

  localparam logic [HIST_MAX_W-1:0] HIST_MASK = HIST_MAX_W'((64'd1 << FILT_LEN) - 64'd1);
`ifdef TRACKBALL_SAT_EN
  localparam logic [CNT_W-1:0] CNT_SMAX = {1'b0, {(CNT_W-1){1'b1}}};
  localparam logic [CNT_W-1:0] CNT_SMIN = {1'b1, {(CNT_W-1){1'b0}}};
`endif

  chan_state_t      r_clk_st;
  chan_state_t      r_dir_st;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_cnt_nxt;
  logic             w_evt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_clk_st <= '0;
      r_dir_st <= '0;
    end else begin
      r_clk_st <= line_step(r_clk_st, i_clk_raw, i_tick, HIST_MASK);
      r_dir_st <= line_step(r_dir_st, i_dir_raw, i_tick, HIST_MASK);
    end
  end

  // Filtered CLK change since the previous tick; rising only in x1 resolution
  assign w_evt = i_tick & (i_resoln ? (r_clk_st.filt & ~r_clk_st.prev)
                                    : (r_clk_st.filt ^ r_clk_st.prev));

  always_comb begin
    w_cnt_nxt = r_cnt;
    if (w_evt) begin
`ifdef TRACKBALL_SAT_EN
      if (r_dir_st.filt) begin
        if (r_cnt != CNT_SMAX) w_cnt_nxt = r_cnt + CNT_W'(1);
      end else if (r_cnt != CNT_SMIN) begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
      end
`else
      w_cnt_nxt = r_dir_st.filt ? r_cnt + CNT_W'(1) : r_cnt - CNT_W'(1);
`endif
    end
  end

  // Clear has priority over a coincident event
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else            r_cnt <= w_cnt_nxt;
  end

  assign o_cnt = r_cnt;

endmodule

// File: rtl/trackball_counter_bank.sv
// N-channel trackball motion counter bank: sample-tick prescaler, per-channel decoders, CPU read port.
// TRACKBALL_SAT_EN defined: counters saturate at 7F/80 (for CNT_W=8) instead of wrapping.
module trackball_counter_bank
  import trackball_pkg::*;
#(
  parameter  int unsigned NCHAN    = 4,
  parameter  int unsigned CNT_W    = 8,
  parameter  int unsigned DIV      = 115,
  parameter  int unsigned FILT_LEN = 3,
  localparam int unsigned AD_W     = (NCHAN > 1) ? $clog2(NCHAN) : 1
) (
  input  logic             GCLK,
  input  logic             RST_N,
  input  logic             CS,
  input  logic [AD_W-1:0]  AD,
  input  logic             CLR,
  input  logic             RESOLN,
  input  logic [NCHAN-1:0] CLKS,
  input  logic [NCHAN-1:0] DIRS,
  output logic [CNT_W-1:0] DB,
  output logic             TICK
);

  localparam int unsigned DIV_W = $clog2(DIV);
  localparam int unsigned NSLOT = 1 << AD_W;

  if (!params_legal(DIV, FILT_LEN, NCHAN)) begin : g_bad_params
    $error("trackball_counter_bank: illegal DIV/FILT_LEN/NCHAN");
  end

  logic [DIV_W-1:0] r_div;
  logic [DIV_W-1:0] w_div_nxt;
  logic             r_tick;
  logic [CNT_W-1:0] r_db;
  logic [CNT_W-1:0] w_cnt [NSLOT];

  assign w_div_nxt = (r_div == DIV_W'(DIV - 1)) ? '0 : r_div + DIV_W'(1);

  // TICK is high exactly while the prescaler sits at DIV-1
  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N) begin
      r_div  <= '0;
      r_tick <= 1'b0;
    end else begin
      r_div  <= w_div_nxt;
      r_tick <= (w_div_nxt == DIV_W'(DIV - 1));
    end
  end

  assign TICK = r_tick;

  // Address slots beyond NCHAN read as zero and have no counter to clear
  for (genvar i = 0; i < NSLOT; i++) begin : g_slot
    if (i < NCHAN) begin : g_chan
      tb_chan_decoder #(
        .CNT_W    (CNT_W),
        .FILT_LEN (FILT_LEN)
      ) u_chan (
        .clk       (GCLK),
        .rst_n     (RST_N),
        .i_tick    (r_tick),
        .i_resoln  (RESOLN),
        .i_clk_raw (CLKS[i]),
        .i_dir_raw (DIRS[i]),
        .i_clr     (~CS & CLR & (AD == AD_W'(i))),
        .o_cnt     (w_cnt[i])
      );
    end else begin : g_empty
      assign w_cnt[i] = '0;
    end
  end

  always_ff @(posedge GCLK or negedge RST_N) begin
    if (!RST_N)   r_db <= '0;
    else if (!CS) r_db <= w_cnt[AD];
  end

  assign DB = r_db;

endmodule

// File: tb/tb_trackball_counter_bank.sv
// Self-checking bench for trackball_counter_bank: directed spec cases plus randomized
// line activity checked against a tick-level behavioural model.
module tb_trackball_counter_bank;

  localparam int unsigned NCHAN    = 4;
  localparam int unsigned CNT_W    = 8;
  localparam int unsigned DIV      = 8;
  localparam int unsigned FILT_LEN = 3;
  localparam int unsigned AD_W     = 2;
  localparam int          MOD      = 1 << CNT_W;

  logic             GCLK   = 1'b0;
  logic             RST_N  = 1'b0;
  logic             CS     = 1'b1;
  logic [AD_W-1:0]  AD     = '0;
  logic             CLR    = 1'b0;
  logic             RESOLN = 1'b1;
  logic [NCHAN-1:0] CLKS   = '0;
  logic [NCHAN-1:0] DIRS   = '0;
  logic [CNT_W-1:0] DB;
  logic             TICK;

  int n_checks = 0;
  int n_errors = 0;

  always #5 GCLK = ~GCLK;

  trackball_counter_bank #(
    .NCHAN    (NCHAN),
    .CNT_W    (CNT_W),
    .DIV      (DIV),
    .FILT_LEN (FILT_LEN)
  ) dut (
    .GCLK   (GCLK),
    .RST_N  (RST_N),
    .CS     (CS),
    .AD     (AD),
    .CLR    (CLR),
    .RESOLN (RESOLN),
    .CLKS   (CLKS),
    .DIRS   (DIRS),
    .DB     (DB),
    .TICK   (TICK)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Behavioural model: per line, the value of the current run of equal tick samples
  int   m_cnt  [NCHAN];
  logic m_fc   [NCHAN];
  logic m_fd   [NCHAN];
  logic m_rvc  [NCHAN];
  logic m_rvd  [NCHAN];
  int   m_rlc  [NCHAN];
  int   m_rld  [NCHAN];
  logic m_hold [NCHAN];

  function automatic int step(input int v, input logic up);
`ifdef TRACKBALL_SAT_EN
    int s;
    s = (v >= MOD / 2) ? v - MOD : v;
    s = up ? s + 1 : s - 1;
    if (s > MOD / 2 - 1) s = MOD / 2 - 1;
    if (s < -(MOD / 2)) s = -(MOD / 2);
    return (s + MOD) % MOD;
`else
    return up ? (v + 1) % MOD : (v + MOD - 1) % MOD;
`endif
  endfunction

  task automatic model_reset();
    for (int ch = 0; ch < NCHAN; ch++) begin
      m_cnt[ch]  = 0;
      m_fc[ch]   = 1'b0;
      m_fd[ch]   = 1'b0;
      m_rvc[ch]  = 1'b0;
      m_rvd[ch]  = 1'b0;
      m_rlc[ch]  = FILT_LEN;
      m_rld[ch]  = FILT_LEN;
      m_hold[ch] = 1'b0;
    end
  endtask

  task automatic model_tick();
    logic c, d, nfc, nfd, evt;
    for (int ch = 0; ch < NCHAN; ch++) begin
      c = CLKS[ch];
      d = DIRS[ch];
      if (c == m_rvc[ch]) begin
        if (m_rlc[ch] < FILT_LEN) m_rlc[ch]++;
      end else begin
        m_rvc[ch] = c;
        m_rlc[ch] = 1;
      end
      if (d == m_rvd[ch]) begin
        if (m_rld[ch] < FILT_LEN) m_rld[ch]++;
      end else begin
        m_rvd[ch] = d;
        m_rld[ch] = 1;
      end
      nfc = (m_rlc[ch] >= FILT_LEN) ? m_rvc[ch] : m_fc[ch];
      nfd = (m_rld[ch] >= FILT_LEN) ? m_rvd[ch] : m_fd[ch];
      evt = RESOLN ? (!m_fc[ch] && nfc) : (m_fc[ch] != nfc);
      if (m_hold[ch]) m_cnt[ch] = 0;
      else if (evt)   m_cnt[ch] = step(m_cnt[ch], nfd);
      m_fc[ch] = nfc;
      m_fd[ch] = nfd;
    end
  endtask

  always @(negedge GCLK) begin
    if (RST_N === 1'b1 && TICK === 1'b1) model_tick();
  end

  // Returns at the falling edge just after the n-th following tick has been taken
  task automatic wait_ticks(input int n);
    int k;
    repeat (n) begin
      k = 0;
      @(negedge GCLK);
      while (TICK !== 1'b1 && k < 4 * DIV) begin
        @(negedge GCLK);
        k++;
      end
      if (k >= 4 * DIV) chk("tick_timeout", 32'(TICK), 32'd1);
      @(negedge GCLK);
    end
  endtask

  task automatic settle();
    wait_ticks(FILT_LEN + 3);
  endtask

  task automatic pulses(input int ch, input int n);
    repeat (n) begin
      CLKS[ch] = 1'b1;
      wait_ticks(FILT_LEN + 1);
      CLKS[ch] = 1'b0;
      wait_ticks(FILT_LEN + 1);
    end
  endtask

  task automatic read_chk(input int ch, input string tag);
    @(negedge GCLK);
    CS  = 1'b0;
    AD  = AD_W'(ch);
    CLR = 1'b0;
    @(negedge GCLK);
    chk(tag, 32'(DB), 32'(m_cnt[ch]));
    CS = 1'b1;
  endtask

  task automatic clear_ch(input int ch);
    @(negedge GCLK);
    CS  = 1'b0;
    AD  = AD_W'(ch);
    CLR = 1'b1;
    @(negedge GCLK);
    CS        = 1'b1;
    CLR       = 1'b0;
    m_cnt[ch] = 0;
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired checks=%0d errors=%0d", n_checks, n_errors);
    $fatal(1);
  end

  initial begin
    int k;
    logic [CNT_W-1:0] seen;
    model_reset();
    repeat (3) @(negedge GCLK);
    chk("rst_db", 32'(DB), 32'd0);
    chk("rst_tick", 32'(TICK), 32'd0);

    // First tick DIV-1 edges after release, one cycle wide
    RST_N = 1'b1;
    k = 0;
    do begin
      @(posedge GCLK);
      #1;
      k++;
    end while (TICK !== 1'b1 && k < 4 * DIV);
    chk("first_tick_edges", 32'(k), 32'(DIV - 1));
    @(posedge GCLK);
    #1;
    chk("tick_one_cycle", 32'(TICK), 32'd0);

    // Ten x1 up pulses on channel 0
    RESOLN  = 1'b1;
    DIRS[0] = 1'b1;
    settle();
    pulses(0, 10);
    settle();
    read_chk(0, "ch0_ten_up");
    chk("ch0_ten_up_const", 32'(DB), 32'h0A);

    // Reset mid-operation clears DB and TICK at once
    @(posedge GCLK);
    #2;
    RST_N = 1'b0;
    #1;
    chk("midrst_db", 32'(DB), 32'd0);
    chk("midrst_tick", 32'(TICK), 32'd0);
    model_reset();
    CLKS = '0;
    DIRS = '0;
    repeat (2) @(negedge GCLK);
    RST_N = 1'b1;
    read_chk(0, "ch0_after_rst");

    // x2 resolution down count on channel 1
    RESOLN = 1'b0;
    settle();
    pulses(1, 3);
    settle();
    read_chk(1, "ch1_x2_down");
    chk("ch1_x2_down_const", 32'(DB), 32'hFA);
    read_chk(0, "ch0_idle");
    read_chk(2, "ch2_idle");
    read_chk(3, "ch3_idle");

    // Glitch filter on channel 2
    RESOLN  = 1'b1;
    DIRS[2] = 1'b1;
    settle();
    CLKS[2] = 1'b1;
    wait_ticks(FILT_LEN - 1);
    CLKS[2] = 1'b0;
    settle();
    read_chk(2, "ch2_glitch_short");
    chk("ch2_glitch_short_const", 32'(DB), 32'h00);
    CLKS[2] = 1'b1;
    wait_ticks(FILT_LEN);
    CLKS[2] = 1'b0;
    settle();
    read_chk(2, "ch2_glitch_exact");
    chk("ch2_glitch_exact_const", 32'(DB), 32'h01);

    // Wrap through zero on channel 0
    clear_ch(0);
    DIRS[0] = 1'b0;
    settle();
    pulses(0, 1);
    settle();
    read_chk(0, "ch0_dec_from_00");
    chk("ch0_dec_from_00_const", 32'(DB), 32'hFF);
    DIRS[0] = 1'b1;
    settle();
    pulses(0, 1);
    settle();
    read_chk(0, "ch0_inc_from_ff");
    chk("ch0_inc_from_ff_const", 32'(DB), 32'h00);
`ifdef TRACKBALL_SAT_EN
    RESOLN = 1'b0;
    settle();
    pulses(0, 64);
    settle();
    read_chk(0, "ch0_sat_hi");
    chk("ch0_sat_hi_const", 32'(DB), 32'h7F);
    DIRS[0] = 1'b0;
    settle();
    pulses(0, 128);
    settle();
    read_chk(0, "ch0_sat_lo");
    chk("ch0_sat_lo_const", 32'(DB), 32'h80);
    RESOLN = 1'b1;
    settle();
`endif

    // Clear held across a channel 3 event: event must never land
    clear_ch(3);
    DIRS[3] = 1'b1;
    settle();
    wait_ticks(1);
    CS        = 1'b0;
    AD        = AD_W'(3);
    CLR       = 1'b1;
    m_hold[3] = 1'b1;
    CLKS[3]   = 1'b1;
    seen      = '0;
    for (int c = 0; c < (FILT_LEN + 4) * DIV; c++) begin
      @(negedge GCLK);
      if (DB !== '0 && seen == '0) seen = DB;
    end
    chk("ch3_clr_window_db", 32'(seen), 32'd0);
    CS        = 1'b1;
    CLR       = 1'b0;
    m_hold[3] = 1'b0;
    settle();
    read_chk(3, "ch3_after_clr");
    CLKS[3] = 1'b0;
    settle();
    pulses(3, 2);
    settle();
    read_chk(3, "ch3_two_up");

    // CLR with CS high: no clear, DB holds
    @(negedge GCLK);
    CS  = 1'b1;
    AD  = AD_W'(3);
    CLR = 1'b1;
    repeat (4) @(negedge GCLK);
    chk("cs_hi_db_hold", 32'(DB), 32'(m_cnt[3]));
    CLR = 1'b0;
    read_chk(3, "ch3_cs_hi_noclr");

    // Randomized line activity including sub-filter glitches
    for (int ph = 0; ph < 4; ph++) begin
      RESOLN = 1'($urandom);
      settle();
      repeat (30) begin
        CLKS = NCHAN'($urandom);
        DIRS = NCHAN'($urandom);
        wait_ticks($urandom_range(1, FILT_LEN + 1));
      end
      settle();
      for (int ch = 0; ch < NCHAN; ch++) read_chk(ch, $sformatf("rand_p%0d_ch%0d", ph, ch));
      if (ph == 1) clear_ch($urandom_range(0, NCHAN - 1));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
